// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl
// Multi-cycle sequencer for the RV32I core. Walks each instruction through
// IF/ID/EX/MEM/WB and shares the single memory port between fetch and
// load/store. It drives the datapath strobes, counts retired instructions,
// and traps on illegal opcodes or on a memory request that never completes.
module rv32i_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [9:0]       func,
  input  logic             br_taken,
  input  logic             mem_rdy,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic [1:0]       mem_size,
  output logic             mem_sext,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_b,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             bus_err
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  // The wait timer fires in the cycle where it would reach TIMEOUT, so the
  // last legal count value is TIMEOUT-1.
  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  state_t           state_reg;
  logic [15:0]      wait_cnt_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             illegal_reg;
  logic             bus_err_reg;

  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_s, is_b, is_u, is_j, is_jr;
  logic       op_legal;
  logic       mem_phase;
  logic       timeout_hit;
  logic       unused_func_hi;

  assign funct3         = func[2:0];
  // Upper func bits (funct7) do not affect sequencing.
  assign unused_func_hi = ^func[9:3];

  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);
  assign is_ld = (op == OP_LD);
  assign is_s  = (op == OP_S);
  assign is_b  = (op == OP_B);
  assign is_u  = (op == OP_U);
  assign is_j  = (op == OP_J);
  assign is_jr = (op == OP_JR);

  // JALR only exists with funct3 == 0; other encodings are reserved.
  assign op_legal = is_r | is_i | is_ld | is_s | is_b | is_u | is_j |
                    (is_jr && (funct3 == 3'd0));

  // mem_rdy wins over the timeout when both land in the same cycle.
  assign mem_phase   = (state_reg == S_IF) || (state_reg == S_MEM);
  assign timeout_hit = mem_phase && !mem_rdy && (wait_cnt_reg == WAIT_LAST);

  // State sequencing, memory wait timer, retire counter and sticky traps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IF;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
      illegal_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IF: begin
          if (mem_rdy) begin
            state_reg    <= S_ID;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            state_reg   <= S_TRAP;
            bus_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        S_ID: begin
          if (op_legal) begin
            state_reg <= S_EX;
          end else begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end
        end
        S_EX: begin
          if (is_b) begin
            state_reg    <= S_IF;
            wait_cnt_reg <= '0;
            retired_reg  <= retired_reg + CNT_ONE;
          end else if (is_ld || is_s) begin
            state_reg    <= S_MEM;
            wait_cnt_reg <= '0;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_rdy) begin
            wait_cnt_reg <= '0;
            if (is_s) begin
              state_reg   <= S_IF;
              retired_reg <= retired_reg + CNT_ONE;
            end else begin
              state_reg <= S_WB;
            end
          end else if (timeout_hit) begin
            state_reg   <= S_TRAP;
            bus_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        S_WB: begin
          state_reg    <= S_IF;
          wait_cnt_reg <= '0;
          retired_reg  <= retired_reg + CNT_ONE;
        end
        S_TRAP: begin
          state_reg <= S_TRAP;
        end
        default: begin
          state_reg <= S_TRAP;
        end
      endcase
    end
  end

  // Datapath strobes from the current state; Mealy on mem_rdy and br_taken.
  // Everything is forced low while rst is high so nothing completes mid-reset.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_size     = 2'd0;
    mem_sext     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_src_b    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    if (!rst) begin
      case (state_reg)
        S_IF: begin
          mem_req  = 1'b1;
          mem_size = 2'd2;
          ir_we    = mem_rdy;
        end
        S_EX: begin
          alu_src_b = !(is_r || is_b);
          if (is_b) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_s;
          mem_size     = funct3[1:0];
          mem_sext     = is_ld && !funct3[2];
          if (mem_rdy && is_s) begin
            pc_we = 1'b1;
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          if (is_ld) begin
            wb_sel = 2'd1;
          end else if (is_j || is_jr) begin
            wb_sel = 2'd2;
          end else if (is_u) begin
            wb_sel = 2'd3;
          end
          if (is_j) begin
            pc_sel = 2'd1;
          end else if (is_jr) begin
            pc_sel = 2'd2;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state   = state_reg;
  assign retired = retired_reg;
  assign illegal = illegal_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It consumes the Decoder's op/func fields and sequences fetch, decode, execute, memory and write-back. It also time-shares the single memory port between instruction fetch and load/store. It drives all datapath strobes and muxes, counts retired instructions, and traps on illegal opcodes or memory timeouts.

Parameters:
TIMEOUT, 255, maximum cycles mem_req may wait for mem_rdy before bus-error trap (1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
op  in  7  Decoder opcode (instr[6:0]) of the latched IR
func  in  10  Decoder func field; func[2:0] = funct3
br_taken  in  1  branch comparator result for current rs1/rs2/func, valid in EX
mem_rdy  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_rdy
mem_we  out  1  1=store, 0=read
mem_addr_sel  out  1  0=PC (fetch), 1=ALU result (load/store)
mem_size  out  2  0=byte, 1=half, 2=word (fetch always 2)
mem_sext  out  1  load sign-extend (LB/LH)
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
pc_sel  out  2  0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
alu_src_b  out  1  0=rs2, 1=imm
reg_we  out  1  register-file write
wb_sel  out  2  0=ALU, 1=MEM, 2=PC+4, 3=IMM
state  out  3  current state (debug)
retired  out  CNT_W  retired-instruction count
illegal  out  1  sticky: illegal opcode trap
bus_err  out  1  sticky: memory timeout trap

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7. Reset: state=IF; retired=0; illegal=bus_err=0; every strobe output 0 except mem_req, which goes to 1 in IF once rst deasserts.
- Strobes are combinational from state and inputs (Mealy where stated). Mux selects are don't-care unless listed; drive 0.
- IF: mem_req=1, mem_we=0, mem_addr_sel=0, mem_size=2. When mem_rdy=1: ir_we=1 in the same cycle, go to ID. Otherwise stay.
- ID: one cycle for register read. Decode op:
  - Legal: R 0110011, I 0010011, ILD 0000011, S 0100011, B 1100011, U(LUI) 0110111, J 1101111, IJR 1100111. Go to EX.
  - Any other op, or IJR with funct3!=0: illegal=1, go to TRAP.
- EX: alu_src_b=0 for R and B; 1 otherwise.
  - B: pc_we=1; pc_sel=1 if br_taken, else 0. Retire, go to IF.
  - ILD and S: go to MEM.
  - R, I, U, J, IJR: go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(op==S), mem_size=funct3[1:0]. mem_sext=~funct3[2] for loads. When mem_rdy=1:
  - Store: pc_we=1, pc_sel=0, retire, go to IF.
  - Load: go to WB.
- WB: reg_we=1, pc_we=1.
  - wb_sel: R/I=0; ILD=1; J/IJR=2; U=3.
  - pc_sel: J=1; IJR=2; others=0.
  - Retire, go to IF.
- Retire: retired increments by 1 on the clock edge that leaves the final state. The counter wraps modulo 2^CNT_W.
- Timeout: a wait counter clears on entry to IF/MEM and on mem_rdy, and increments each cycle mem_req=1 without mem_rdy. When it reaches TIMEOUT: bus_err=1, go to TRAP, no strobes that cycle. mem_rdy in the same cycle as reaching TIMEOUT wins (normal completion).
- TRAP: all strobes 0, mem_req=0. Stays until rst; illegal/bus_err hold.
- mem_rdy while mem_req=0 is ignored.
- rst mid-instruction: immediate return to reset values. No partial write completes after the asynchronous assertion.
- Latency with mem_rdy in the first request cycle:
  - B: 3 cycles.
  - R/I/U/J/IJR/S: 4 cycles.
  - ILD: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- mem_rdy tied 1, IR=0x002081B3 (add x3,x1,x2): states IF,ID,EX,WB; WB has reg_we=1, wb_sel=0, pc_sel=0; retired 0->1 after 4 cycles.
- IR=0x0080A283 (lw x5,8(x1)), mem_rdy low 2 cycles in MEM: MEM holds mem_req=1, mem_addr_sel=1, mem_size=2, mem_we=0 for 3 cycles; then WB with wb_sel=1; total 7 cycles.
- IR=0x00208463 (beq) with br_taken=1, then again with br_taken=0: EX pc_we=1 with pc_sel=1, then pc_sel=0; 3 cycles each; reg_we never 1.
- IR=0x0000007F (op=1111111): ID->TRAP, illegal=1, mem_req stays 0 for 20 cycles; retired unchanged; rst pulse returns to IF with illegal=0.
- TIMEOUT=4, mem_rdy held 0 in IF: after 4 request cycles bus_err=1, state=7. Repeat with mem_rdy=1 on the 4th cycle: normal ID, bus_err=0.
- Assert rst during MEM of sw (0x0020A423) with mem_rdy=0: mem_req/mem_we drop asynchronously, state=IF, retired=0; no pc_we seen.
